// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between a fetch
// requester and a data requester; one transaction in flight at a time.
module mem_arbiter #(
    parameter int ADDRSIZE = 8,
    parameter int WORDSIZE = 64,
    parameter int MEMLAT   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDRSIZE-1:0] i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [WORDSIZE-1:0] i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDRSIZE-1:0] d_addr,
    input  logic [WORDSIZE-1:0] d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [WORDSIZE-1:0] d_rdata,
    output logic                m_en,
    output logic                m_wren,
    output logic [ADDRSIZE-1:0] m_addr,
    output logic [WORDSIZE-1:0] m_d,
    input  logic [WORDSIZE-1:0] m_q
);
    localparam logic [3:0] LAT = 4'(MEMLAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_r;
    logic [3:0] cnt_r;
    logic       sel_d_r;
    logic       we_r;
    logic       last_d_r;
    logic       pick_d_s;

    // Winner select: a lone requester always wins; on a tie data wins unless it won last.
    always_comb begin
        pick_d_s = 1'b0;
        if (d_req && (!i_req || !last_d_r)) begin
            pick_d_s = 1'b1;
        end else begin
            pick_d_s = 1'b0;
        end
    end

    // Transaction sequencing, latency count and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= 4'd0;
            sel_d_r  <= 1'b0;
            we_r     <= 1'b0;
            last_d_r <= 1'b0;
            i_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_rdata  <= {WORDSIZE{1'b0}};
            d_rdata  <= {WORDSIZE{1'b0}};
            m_en     <= 1'b0;
            m_wren   <= 1'b0;
            m_addr   <= {ADDRSIZE{1'b0}};
            m_d      <= {WORDSIZE{1'b0}};
        end else begin
            i_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (i_req || d_req) begin
                        state_r  <= WAIT;
                        cnt_r    <= LAT;
                        sel_d_r  <= pick_d_s;
                        last_d_r <= pick_d_s;
                        m_en     <= 1'b1;
                        if (pick_d_s) begin
                            d_gnt  <= 1'b1;
                            we_r   <= d_we;
                            m_wren <= d_we;
                            m_addr <= d_addr;
                            m_d    <= d_wdata;
                        end else begin
                            i_gnt  <= 1'b1;
                            we_r   <= 1'b0;
                            m_wren <= 1'b0;
                            m_addr <= i_addr;
                            m_d    <= {WORDSIZE{1'b0}};
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT: begin
                    // Memory output is valid during the last WAIT cycle.
                    if (cnt_r == 4'd1) begin
                        state_r <= DONE;
                        cnt_r   <= 4'd0;
                        m_en    <= 1'b0;
                        m_wren  <= 1'b0;
                        m_addr  <= {ADDRSIZE{1'b0}};
                        m_d     <= {WORDSIZE{1'b0}};
                        if (sel_d_r) begin
                            d_rvalid <= 1'b1;
                            if (!we_r) begin
                                d_rdata <= m_q;
                            end else begin
                                d_rdata <= d_rdata;
                            end
                        end else begin
                            i_rvalid <= 1'b1;
                            i_rdata  <= m_q;
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level timeline model; a second MEMLAT=1 instance.
module tb_mem_arbiter;
    localparam int AW  = 8;
    localparam int DW  = 64;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0, m_addr;
    logic [DW-1:0] d_wdata = '0, m_q = '0;
    logic          i_gnt, i_rvalid, d_gnt, d_rvalid, m_en, m_wren;
    logic [DW-1:0] i_rdata, d_rdata, m_d;

    logic          i_req1 = 1'b0;
    logic [DW-1:0] q1 = '0;
    logic          i_gnt1, i_rvalid1, d_gnt1, d_rvalid1, m_en1, m_wren1;
    logic [DW-1:0] i_rdata1, d_rdata1, m_d1;
    logic [AW-1:0] m_addr1;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDRSIZE(AW), .WORDSIZE(DW), .MEMLAT(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_wren(m_wren), .m_addr(m_addr), .m_d(m_d), .m_q(m_q)
    );

    mem_arbiter #(.ADDRSIZE(AW), .WORDSIZE(DW), .MEMLAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .i_req(i_req1), .i_addr(8'h33), .i_gnt(i_gnt1), .i_rvalid(i_rvalid1), .i_rdata(i_rdata1),
        .d_req(1'b0), .d_we(1'b0), .d_addr(8'h00), .d_wdata(64'h0),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .m_en(m_en1), .m_wren(m_wren1), .m_addr(m_addr1), .m_d(m_d1), .m_q(q1)
    );

    int checks = 0;
    int errors = 0;
    int e = 0;

    // Timeline model: one transaction record plus when the arbiter is next free.
    int            free_edge, t_edge;
    bit            last_d, t_valid, t_d, t_we, mg_i, mg_d;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata, exp_i_rdata, exp_d_rdata;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        free_edge   = e;
        last_d      = 1'b0;
        t_valid     = 1'b0;
        mg_i        = 1'b0;
        mg_d        = 1'b0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
    endtask

    task automatic step(input bit ir, input logic [AW-1:0] ia, input bit dr, input bit dwe,
                        input logic [AW-1:0] da, input logic [DW-1:0] dw, input logic [DW-1:0] mq);
        bit win_d;
        bit en;
        i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dw; m_q = mq;
        mg_i = 1'b0;
        mg_d = 1'b0;
        if (t_valid && e == t_edge + LAT) begin
            if (!t_d) exp_i_rdata = mq;
            else if (!t_we) exp_d_rdata = mq;
        end
        if (e >= free_edge && (ir || dr)) begin
            if (ir && dr) win_d = !last_d;
            else win_d = dr;
            last_d    = win_d;
            t_valid   = 1'b1;
            t_d       = win_d;
            t_we      = win_d && dwe;
            t_addr    = win_d ? da : ia;
            t_wdata   = win_d ? dw : 64'h0;
            t_edge    = e;
            free_edge = e + LAT + 2;
            mg_i      = !win_d;
            mg_d      = win_d;
        end
        @(posedge clk);
        #1;
        en = t_valid && e >= t_edge && e < t_edge + LAT;
        chk("i_gnt",    64'(i_gnt),    64'(t_valid && e == t_edge && !t_d));
        chk("d_gnt",    64'(d_gnt),    64'(t_valid && e == t_edge && t_d));
        chk("m_en",     64'(m_en),     64'(en));
        chk("m_wren",   64'(m_wren),   64'(en && t_we));
        chk("m_addr",   64'(m_addr),   en ? 64'(t_addr) : 64'h0);
        chk("m_d",      m_d,           en ? t_wdata : 64'h0);
        chk("i_rvalid", 64'(i_rvalid), 64'(t_valid && e == t_edge + LAT && !t_d));
        chk("d_rvalid", 64'(d_rvalid), 64'(t_valid && e == t_edge + LAT && t_d));
        chk("i_rdata",  i_rdata,       exp_i_rdata);
        chk("d_rdata",  d_rdata,       exp_d_rdata);
        e++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 64'h0, 64'(k));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_req = 1'b0; d_req = 1'b0; i_req1 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        bit            ip, dp, pwe;
        logic [AW-1:0] pia, pda;
        logic [DW-1:0] pdw, exp_rd1;
        int            gc, rc;
        ip = 1'b0; dp = 1'b0; pwe = 1'b0; pia = '0; pda = '0; pdw = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_i_gnt", 64'(i_gnt), 64'h0);
        chk("rst_d_gnt", 64'(d_gnt), 64'h0);
        chk("rst_i_rvalid", 64'(i_rvalid), 64'h0);
        chk("rst_d_rvalid", 64'(d_rvalid), 64'h0);
        chk("rst_m_en", 64'(m_en), 64'h0);
        chk("rst_m_wren", 64'(m_wren), 64'h0);
        chk("rst_i_rdata", i_rdata, 64'h0);
        chk("rst_d_rdata", d_rdata, 64'h0);
        rst = 1'b0;
        model_reset();

        // Single fetch read.
        step(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 64'h0, 64'h0);
        chk("fetch_gnt", 64'(i_gnt), 64'h1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 64'h0, 64'hAAAA);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 64'h0, 64'hAAAA);
        chk("fetch_rvalid", 64'(i_rvalid), 64'h1);
        chk("fetch_rdata", i_rdata, 64'hAAAA);
        idle(1);

        // Data write: d_rdata must be untouched.
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 64'h1234, 64'hDEAD);
        chk("wr_m_wren", 64'(m_wren), 64'h1);
        chk("wr_m_addr", 64'(m_addr), 64'h20);
        chk("wr_m_d", m_d, 64'h1234);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 64'h0, 64'hBEEF);
        chk("wr_m_wren2", 64'(m_wren), 64'h1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 64'h0, 64'hBEEF);
        chk("wr_d_rvalid", 64'(d_rvalid), 64'h1);
        chk("wr_d_rdata", d_rdata, 64'h0);
        idle(1);

        // Continuous tie after reset: D, I, D, I.
        do_reset();
        for (int s = 0; s < 16; s++) begin
            step(1'b1, 8'(8'h40 + s), 1'b1, 1'b0, 8'(8'h80 + s), 64'(s), {$urandom, $urandom});
            if (s % 4 == 0) chk("tie_order", 64'(((s / 4) % 2 == 0) ? d_gnt : i_gnt), 64'h1);
        end
        idle(4);

        // Reset in the second WAIT cycle of a write aborts it.
        do_reset();
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h44, 64'h5555, 64'h0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 64'h0, 64'h0);
        chk("pre_abort_m_wren", 64'(m_wren), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_m_en", 64'(m_en), 64'h0);
        chk("abort_m_wren", 64'(m_wren), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step(1'b1, 8'h11, 1'b1, 1'b0, 8'h22, 64'h0, 64'h0);
        chk("abort_tie_d", 64'(d_gnt), 64'h1);
        idle(LAT + 2);

        // Randomized traffic; requesters hold until granted.
        for (int n = 0; n < 400; n++) begin
            if (!ip && $urandom_range(0, 2) == 0) begin
                ip = 1'b1; pia = 8'($urandom);
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                dp = 1'b1; pwe = 1'($urandom_range(0, 1)); pda = 8'($urandom); pdw = {$urandom, $urandom};
            end
            step(ip, pia, dp, pwe, pda, pdw, {$urandom, $urandom});
            if (mg_i) ip = 1'b0;
            if (mg_d) dp = 1'b0;
        end
        idle(LAT + 2);

        // MEMLAT=1 instance under continuous fetch requests.
        gc = 0; rc = 0; exp_rd1 = '0;
        for (int j = 0; j < 30; j++) begin
            i_req1 = 1'b1;
            q1 = {$urandom, $urandom};
            if (j % 3 == 1) exp_rd1 = q1;
            @(posedge clk);
            #1;
            chk("ml1_gnt", 64'(i_gnt1), 64'(j % 3 == 0));
            chk("ml1_rvalid", 64'(i_rvalid1), 64'(j % 3 == 1));
            chk("ml1_m_en", 64'(m_en1), 64'(j % 3 == 0));
            chk("ml1_rdata", i_rdata1, exp_rd1);
            gc += int'(i_gnt1);
            rc += int'(i_rvalid1);
        end
        i_req1 = 1'b0;
        chk("ml1_gnt_count", 64'(gc), 64'd10);
        chk("ml1_rvalid_count", 64'(rc), 64'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
